// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - shared decode types, field positions and the empty-record default
package decode_queue_pkg;

    localparam int TYPE_LSB    = 0;
    localparam int SUBTYPE_LSB = 2;
    localparam int REG_LSB     = 5;
    localparam int IMM_LSB     = 8;

    typedef enum logic [2:0] {
        ALU_SL, ALU_SR, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MUL
    } alu_operation_t;

    typedef enum logic {ALU_RX, ALU_IMMEDIATE} alu_operand_t;

    typedef enum logic {RF_MUX_ALU, RF_MUX_MEM} rf_mux_src_t;

    typedef enum logic [1:0] {CORE_NOP, CORE_HALT, CORE_RESET} core_special_operation_t;

    typedef enum logic [1:0] {RASTER_CMD_FILL, RASTER_CMD_POINT, RASTER_CMD_LINE} raster_command_t;

    // The immediate is width-parametrised, so it travels beside this record in the queue.
    typedef struct packed {
        logic [1:0]              inst_type;
        logic [2:0]              inst_subtype;
        logic [2:0]              rf_write_addr;
        logic [2:0]              rx_addr;
        alu_operation_t          alu_operation;
        alu_operand_t            alu_operand;
        rf_mux_src_t             rf_mux_src;
        core_special_operation_t core_special_op;
        raster_command_t         gpu_command;
        logic                    submit;
        logic                    illegal;
    } decoded_inst_t;

    localparam decoded_inst_t DECODE_EMPTY_DEFAULT = '{
        inst_type:       2'd0,
        inst_subtype:    3'd0,
        rf_write_addr:   3'd0,
        rx_addr:         3'd0,
        alu_operation:   ALU_SL,
        alu_operand:     ALU_RX,
        rf_mux_src:      RF_MUX_ALU,
        core_special_op: CORE_NOP,
        gpu_command:     RASTER_CMD_FILL,
        submit:          1'b0,
        illegal:         1'b0
    };

endpackage

// File: rtl/decode_queue_fifo.sv
// rtl/decode_queue_fifo.sv - DEPTH x WIDTH register FIFO with count, pointer wrap and flush
module decode_queue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_fire, rd_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on stored count and flush, never on the consumer side.
    assign wr_ready = (count_q < CNT_W'(DEPTH)) & ~flush;
    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (rd_fire) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - single-cycle instruction decode feeding a DEPTH-entry record queue
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int INST_WIDTH = 16,
    parameter int DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    inst_valid,
    input  logic [INST_WIDTH-1:0]   inst,
    output logic                    inst_ready,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [INST_WIDTH-9:0]   immediate,
    output logic [1:0]              inst_type,
    output logic [2:0]              inst_subtype,
    output logic [2:0]              rf_write_addr,
    output logic [2:0]              rX_addr,
    output alu_operation_t          alu_operation,
    output alu_operand_t            alu_operand,
    output rf_mux_src_t             rf_mux_src,
    output core_special_operation_t core_special_op,
    output raster_command_t         gpu_command,
    output logic                    gpu_submit,
    output logic                    illegal
);

    localparam int IMM_WIDTH = INST_WIDTH - 8;
    localparam int REC_WIDTH = IMM_WIDTH + $bits(decoded_inst_t);

    decoded_inst_t          dec_rec, fifo_rec, head_rec;
    logic [IMM_WIDTH-1:0]   fifo_imm;
    logic [REC_WIDTH-1:0]   fifo_rd_data;
    logic [1:0]             f_type;
    logic [2:0]             f_sub, f_reg;

    assign f_type = inst[TYPE_LSB +: 2];
    assign f_sub  = inst[SUBTYPE_LSB +: 3];
    assign f_reg  = inst[REG_LSB +: 3];

    always_comb begin
        dec_rec               = DECODE_EMPTY_DEFAULT;
        dec_rec.inst_type     = f_type;
        dec_rec.inst_subtype  = f_sub;
        dec_rec.alu_operation = alu_operation_t'(f_sub);
        case (f_type)
            2'b11: dec_rec.alu_operand = ALU_IMMEDIATE;
            2'b10: begin
                dec_rec.rf_write_addr = f_reg;
                dec_rec.rx_addr       = f_reg;
            end
            2'b01: begin
                if (f_sub == 3'b000) begin
                    dec_rec.rf_write_addr = f_reg;
                end else begin
                    dec_rec.rx_addr = f_reg;
                    if (f_sub == 3'b001) dec_rec.rf_mux_src = RF_MUX_MEM;
                end
            end
            default: ;
        endcase
        if (f_type == 2'b00 && f_sub == 3'b111) begin
            case (f_reg)
                3'b000:  dec_rec.core_special_op = CORE_NOP;
                3'b001:  dec_rec.core_special_op = CORE_HALT;
                3'b111:  dec_rec.core_special_op = CORE_RESET;
                default: dec_rec.illegal         = 1'b1;
            endcase
        end
        // Only a legal raster op carries the submit bit; it is acted on at dequeue time.
        if (f_type == 2'b11 && f_sub == 3'b111) begin
            case (f_reg)
                3'b000: begin dec_rec.gpu_command = RASTER_CMD_FILL;  dec_rec.submit = 1'b1; end
                3'b001: begin dec_rec.gpu_command = RASTER_CMD_POINT; dec_rec.submit = 1'b1; end
                3'b010: begin dec_rec.gpu_command = RASTER_CMD_LINE;  dec_rec.submit = 1'b1; end
                default: dec_rec.illegal = 1'b1;
            endcase
        end
    end

    decode_queue_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_valid (inst_valid),
        .wr_data  ({inst[INST_WIDTH-1:IMM_LSB], dec_rec}),
        .wr_ready (inst_ready),
        .rd_valid (dec_valid),
        .rd_data  (fifo_rd_data),
        .rd_ready (dec_ready)
    );

    assign {fifo_imm, fifo_rec} = fifo_rd_data;
    assign head_rec  = dec_valid ? fifo_rec : DECODE_EMPTY_DEFAULT;
    assign immediate = dec_valid ? fifo_imm : '0;

    assign inst_type       = head_rec.inst_type;
    assign inst_subtype    = head_rec.inst_subtype;
    assign rf_write_addr   = head_rec.rf_write_addr;
    assign rX_addr         = head_rec.rx_addr;
    assign alu_operation   = head_rec.alu_operation;
    assign alu_operand     = head_rec.alu_operand;
    assign rf_mux_src      = head_rec.rf_mux_src;
    assign core_special_op = head_rec.core_special_op;
    assign gpu_command     = head_rec.gpu_command;
    assign illegal         = head_rec.illegal;
    assign gpu_submit      = dec_valid & dec_ready & head_rec.submit & ~flush;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized and directed bench for decode_queue against a queue-based model
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic inst_valid = 1'b0;
    logic [15:0] inst = '0;
    logic dec_ready = 1'b0;
    logic inst_ready, dec_valid, gpu_submit, illegal;
    logic [7:0] immediate;
    logic [1:0] inst_type;
    logic [2:0] inst_subtype, rf_write_addr, rX_addr;
    alu_operation_t alu_operation;
    alu_operand_t alu_operand;
    rf_mux_src_t rf_mux_src;
    core_special_operation_t core_special_op;
    raster_command_t gpu_command;

    int n_checks = 0;
    int n_errors = 0;
    int submit_cnt = 0;
    raster_command_t last_cmd = RASTER_CMD_FILL;
    logic [15:0] mq[$];

    always #5 clk = ~clk;

    decode_queue #(.INST_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .immediate(immediate), .inst_type(inst_type), .inst_subtype(inst_subtype),
        .rf_write_addr(rf_write_addr), .rX_addr(rX_addr),
        .alu_operation(alu_operation), .alu_operand(alu_operand),
        .rf_mux_src(rf_mux_src), .core_special_op(core_special_op),
        .gpu_command(gpu_command), .gpu_submit(gpu_submit), .illegal(illegal)
    );

    typedef struct packed {
        logic [7:0] imm;
        logic [1:0] typ;
        logic [2:0] sub;
        logic [2:0] rfw;
        logic [2:0] rx;
        alu_operation_t aop;
        alu_operand_t opnd;
        rf_mux_src_t mux;
        core_special_operation_t sop;
        raster_command_t gcmd;
        logic submit;
        logic ill;
    } exp_t;

    function automatic exp_t empty_exp();
        exp_t e;
        e = '{imm: 8'h00, typ: 2'b00, sub: 3'b000, rfw: 3'b000, rx: 3'b000, aop: ALU_SL,
              opnd: ALU_RX, mux: RF_MUX_ALU, sop: CORE_NOP, gcmd: RASTER_CMD_FILL,
              submit: 1'b0, ill: 1'b0};
        return e;
    endfunction

    function automatic exp_t model_decode(input logic [15:0] w);
        exp_t e;
        logic [2:0] r;
        e = empty_exp();
        e.imm = w[15:8];
        e.typ = w[1:0];
        e.sub = w[4:2];
        r = w[7:5];
        case (e.sub)
            3'd0: e.aop = ALU_SL;
            3'd1: e.aop = ALU_SR;
            3'd2: e.aop = ALU_ADD;
            3'd3: e.aop = ALU_SUB;
            3'd4: e.aop = ALU_AND;
            3'd5: e.aop = ALU_OR;
            3'd6: e.aop = ALU_XOR;
            default: e.aop = ALU_MUL;
        endcase
        if (e.typ == 2'd3) e.opnd = ALU_IMMEDIATE;
        if (e.typ == 2'd2) begin e.rfw = r; e.rx = r; end
        if (e.typ == 2'd1 && e.sub == 3'd0) e.rfw = r;
        if (e.typ == 2'd1 && e.sub != 3'd0) e.rx = r;
        if (e.typ == 2'd1 && e.sub == 3'd1) e.mux = RF_MUX_MEM;
        if (e.typ == 2'd0 && e.sub == 3'd7) begin
            if (r == 3'd1) e.sop = CORE_HALT;
            else if (r == 3'd7) e.sop = CORE_RESET;
            else if (r != 3'd0) e.ill = 1'b1;
        end
        if (e.typ == 2'd3 && e.sub == 3'd7) begin
            if (r == 3'd1) e.gcmd = RASTER_CMD_POINT;
            else if (r == 3'd2) e.gcmd = RASTER_CMD_LINE;
            if (r <= 3'd2) e.submit = 1'b1;
            else e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_valid, input logic exp_rdy, input exp_t e,
                                 input logic exp_submit);
        check("inst_ready", inst_ready, exp_rdy);
        check("dec_valid", dec_valid, exp_valid);
        check("immediate", immediate, e.imm);
        check("inst_type", inst_type, e.typ);
        check("inst_subtype", inst_subtype, e.sub);
        check("rf_write_addr", rf_write_addr, e.rfw);
        check("rX_addr", rX_addr, e.rx);
        check("alu_operation", alu_operation, e.aop);
        check("alu_operand", alu_operand, e.opnd);
        check("rf_mux_src", rf_mux_src, e.mux);
        check("core_special_op", core_special_op, e.sop);
        check("gpu_command", gpu_command, e.gcmd);
        check("illegal", illegal, e.ill);
        check("gpu_submit", gpu_submit, exp_submit);
    endtask

    task automatic cycle(input logic iv, input logic [15:0] w, input logic dr, input logic fl);
        exp_t e;
        logic exp_rdy, push, pop, have;
        @(negedge clk);
        inst_valid = iv; inst = w; dec_ready = dr; flush = fl;
        #1;
        have = (mq.size() > 0);
        exp_rdy = (mq.size() < DEPTH) && !fl;
        e = empty_exp();
        if (have) e = model_decode(mq[0]);
        check_outputs(have, exp_rdy, e, have && dr && !fl && e.submit);
        if (gpu_submit) begin submit_cnt++; last_cmd = gpu_command; end
        push = iv && exp_rdy;
        pop = have && dr && !fl;
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(w);
        end
        #1;
        inst_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    logic [15:0] sp_inst [3] = '{16'h003C, 16'h00FC, 16'h005C};
    core_special_operation_t sp_exp [3] = '{CORE_HALT, CORE_RESET, CORE_NOP};
    logic sp_ill [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        #1;
        check_outputs(1'b0, 1'b1, empty_exp(), 1'b0);
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 16'h0569, 1'b0, 1'b0);
        probe();
        check("tp1_valid", dec_valid, 1'b1);
        check("tp1_imm", immediate, 8'h05);
        check("tp1_aop", alu_operation, ALU_ADD);
        check("tp1_rx", rX_addr, 3'd3);
        check("tp1_rfw", rf_write_addr, 3'd0);
        check("tp1_mux", rf_mux_src, RF_MUX_ALU);
        check("tp1_ill", illegal, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        cycle(1'b1, 16'h04C3, 1'b0, 1'b0);
        cycle(1'b1, 16'h0569, 1'b0, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        probe();
        check("tp2_full_ready", inst_ready, 1'b0);
        check("tp2_head_aop", alu_operation, ALU_SL);
        check("tp2_head_imm", immediate, 8'h04);
        check("tp2_head_opnd", alu_operand, ALU_IMMEDIATE);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        submit_cnt = 0;
        cycle(1'b1, 16'h005F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        check("tp3_submit_once", submit_cnt, 1);
        check("tp3_submit_cmd", last_cmd, RASTER_CMD_LINE);
        cycle(1'b1, 16'h007F, 1'b0, 1'b0);
        probe();
        check("tp3_illegal", illegal, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("tp3_no_submit_illegal", submit_cnt, 1);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, sp_inst[i], 1'b0, 1'b0);
            probe();
            check("tp4_sop", core_special_op, sp_exp[i]);
            check("tp4_ill", illegal, sp_ill[i]);
            cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        end

        cycle(1'b1, 16'h005F, 1'b0, 1'b0);
        cycle(1'b1, 16'h005F, 1'b0, 1'b0);
        submit_cnt = 0;
        cycle(1'b1, 16'h0569, 1'b1, 1'b1);
        probe();
        check("tp5_valid", dec_valid, 1'b0);
        check("tp5_ready", inst_ready, 1'b1);
        check("tp5_no_submit", submit_cnt, 0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            if (i == 40) begin
                @(negedge clk);
                inst_valid = 1'b1; inst = 16'h005F; dec_ready = 1'b1;
                #3 rst = 1'b1;
                #1;
                check_outputs(1'b0, 1'b1, empty_exp(), 1'b0);
                mq.delete();
                @(negedge clk);
                inst_valid = 1'b0; dec_ready = 1'b0;
                rst = 1'b0;
            end
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
